exc_ctrl: RTL and testbench

Exception controller for the multicycle MIPS CPU. It consumes the arithmetic-overflow flag that the ALU error checker raises for add/sub/addi, plus an optional external interrupt line. On an exception it kills the faulting instruction's register writeback, records EPC/Cause, sets EXL and redirects the PC to the exception vector. It sits beside the main control FSM and executes `eret` by redirecting back to EPC and clearing EXL.

---
 rtl/exc_pkg.sv | 16 +
 rtl/exc_cp0_regs.sv | 35 +++
 rtl/exc_ctrl.sv | 93 +++++++++
 tb/tb_exc_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared ExcCodes, FSM state encoding and default handler vector for the exception controller.
// No logic, so no latency; no flow control.
// The interrupt path is selected in the top level by the EXC_IRQ_EN macro.
package exc_pkg;

    localparam logic [4:0]  EXC_INT            = 5'd0;
    localparam logic [4:0]  EXC_OV             = 5'd12;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ENTER = 2'd1,
        LEAVE = 2'd2
    } state_t;

endpackage

// File: rtl/exc_cp0_regs.sv
// EPC/Cause/Exl state, loaded on exception entry and with Exl cleared on eret return.
// New values are visible one cycle after load or clear.
// No flow control; the load and clear enables are never refused.
module exc_cp0_regs
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] epc_in,
    input  logic [4:0]  cause_in,
    input  logic        exl_clr,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic        exl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc   <= 32'd0;
            cause <= EXC_INT;
            exl   <= 1'b0;
        end else if (load) begin
            cause <= cause_in;
            exl   <= 1'b1;
            // A nested exception keeps the EPC of the first one so eret returns there.
            if (!exl) begin
                epc <= epc_in;
            end
        end else if (exl_clr) begin
            exl <= 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// MIPS exception controller: kills overflowing writebacks, enters the vector, and returns on eret.
// RegWriteKill is combinational; Redirect follows one cycle after ExDone; Exl clears two cycles after eret.
// No flow control; ExDone is ignored while Busy. Build with EXC_IRQ_EN for the external interrupt path.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Err,
    input  logic        ExDone,
    input  logic [31:0] InstrPC,
    input  logic        Eret,
    input  logic        Irq,
    output logic        RegWriteKill,
    output logic        Redirect,
    output logic [31:0] Target,
    output logic [31:0] EPC,
    output logic [4:0]  Cause,
    output logic        Exl,
    output logic        Busy
);

    state_t      state;
    state_t      state_next;
    logic        kill;
    logic        load;
    logic [31:0] epc_new;
    logic [4:0]  cause_new;
    logic        irq_unused;

    assign irq_unused = Irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        kill       = 1'b0;
        load       = 1'b0;
        epc_new    = InstrPC;
        cause_new  = EXC_OV;
        case (state)
            RUN: begin
                if (ExDone) begin
                    if (Eret && Exl) begin
                        state_next = LEAVE;
                    end else if (Err) begin
                        kill       = 1'b1;
                        load       = 1'b1;
                        state_next = ENTER;
`ifdef EXC_IRQ_EN
                    end else if (Irq && !Exl) begin
                        // The interrupted instruction retires, so resume after it.
                        load       = 1'b1;
                        cause_new  = EXC_INT;
                        epc_new    = InstrPC + 32'd4;
                        state_next = ENTER;
`endif
                    end
                end
            end
            ENTER:   state_next = RUN;
            LEAVE:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    exc_cp0_regs u_cp0_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .epc_in   (epc_new),
        .cause_in (cause_new),
        .exl_clr  (state == LEAVE),
        .epc      (EPC),
        .cause    (Cause),
        .exl      (Exl)
    );

    assign RegWriteKill = kill & rst_n;
    assign Redirect     = (state == ENTER) || (state == LEAVE);
    assign Busy         = Redirect;
    assign Target       = (state == ENTER) ? VECTOR :
                          (state == LEAVE) ? EPC    : 32'd0;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: overflow entry, eret, nesting, masking, interrupts and async reset.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Err, ExDone, Eret, Irq;
    logic [31:0] InstrPC;
    logic        RegWriteKill, Redirect, Exl, Busy;
    logic [31:0] Target, EPC;
    logic [4:0]  Cause;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] VEC = 32'h8000_0180;

    exc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Err          (Err),
        .ExDone       (ExDone),
        .InstrPC      (InstrPC),
        .Eret         (Eret),
        .Irq          (Irq),
        .RegWriteKill (RegWriteKill),
        .Redirect     (Redirect),
        .Target       (Target),
        .EPC          (EPC),
        .Cause        (Cause),
        .Exl          (Exl),
        .Busy         (Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ExDone = 1'b0; Err = 1'b0; Eret = 1'b0; Irq = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; idle(); InstrPC = 32'd0;
        ExDone = 1'b1; Err = 1'b1;
        #12;
        check("rst_kill", RegWriteKill, 0);
        check("rst_redirect", Redirect, 0);
        check("rst_target", Target, 0);
        check("rst_epc", EPC, 0);
        check("rst_cause", Cause, 0);
        check("rst_exl", Exl, 0);
        check("rst_busy", Busy, 0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // overflow entry
        ExDone = 1'b1; Err = 1'b1; InstrPC = 32'h0040_0010;
        #1 check("ov_kill", RegWriteKill, 1);
        tick(); idle();
        check("ov_redirect", Redirect, 1);
        check("ov_target", Target, VEC);
        check("ov_epc", EPC, 32'h0040_0010);
        check("ov_cause", Cause, 12);
        check("ov_exl", Exl, 1);
        check("ov_busy", Busy, 1);
        check("ov_kill_after", RegWriteKill, 0);
        tick();
        check("ov_redirect_end", Redirect, 0);
        check("ov_busy_end", Busy, 0);
        check("ov_exl_hold", Exl, 1);

        // nested overflow keeps EPC
        ExDone = 1'b1; Err = 1'b1; InstrPC = 32'h8000_0190;
        #1 check("nest_kill", RegWriteKill, 1);
        tick(); idle();
        check("nest_redirect", Redirect, 1);
        check("nest_target", Target, VEC);
        check("nest_epc", EPC, 32'h0040_0010);
        check("nest_cause", Cause, 12);
        // ExDone during ENTER is ignored
        ExDone = 1'b1; Err = 1'b1; InstrPC = 32'h1234_5678;
        #1 check("enter_kill", RegWriteKill, 0);
        tick(); idle();
        check("enter_ignore_redirect", Redirect, 0);
        check("enter_ignore_epc", EPC, 32'h0040_0010);

        // Irq masked while Exl=1
        ExDone = 1'b1; Irq = 1'b1; InstrPC = 32'h8000_01a0;
        tick(); idle();
        check("mask_redirect", Redirect, 0);
        check("mask_exl", Exl, 1);
        check("mask_epc", EPC, 32'h0040_0010);

        // eret (Err ignored)
        ExDone = 1'b1; Eret = 1'b1; Err = 1'b1;
        #1 check("eret_kill", RegWriteKill, 0);
        tick(); idle();
        check("eret_redirect", Redirect, 1);
        check("eret_target", Target, 32'h0040_0010);
        check("eret_exl_mid", Exl, 1);
        tick();
        check("eret_redirect_end", Redirect, 0);
        check("eret_exl_clear", Exl, 0);

        // eret with Exl=0 is a no-op
        ExDone = 1'b1; Eret = 1'b1;
        tick(); idle();
        check("noop_eret_redirect", Redirect, 0);
        check("noop_eret_exl", Exl, 0);

`ifdef EXC_IRQ_EN
        ExDone = 1'b1; Irq = 1'b1; InstrPC = 32'h0040_0020;
        #1 check("irq_kill", RegWriteKill, 0);
        tick(); idle();
        check("irq_redirect", Redirect, 1);
        check("irq_target", Target, VEC);
        check("irq_epc", EPC, 32'h0040_0024);
        check("irq_cause", Cause, 0);
        check("irq_exl", Exl, 1);
        tick();
        ExDone = 1'b1; Eret = 1'b1;
        tick(); idle();
        check("irq_ret_target", Target, 32'h0040_0024);
        tick();
        ExDone = 1'b1; Irq = 1'b1; Err = 1'b1; InstrPC = 32'h0040_0030;
        #1 check("irqov_kill", RegWriteKill, 1);
        tick(); idle();
        check("irqov_cause", Cause, 12);
        check("irqov_epc", EPC, 32'h0040_0030);
        tick();
        ExDone = 1'b1; Eret = 1'b1;
        tick(); idle();
        tick();
        ExDone = 1'b1; Irq = 1'b1; InstrPC = 32'hFFFF_FFFC;
        tick(); idle();
        check("irq_wrap_epc", EPC, 32'h0000_0000);
        tick();
        ExDone = 1'b1; Eret = 1'b1;
        tick(); idle();
        tick();
`else
        ExDone = 1'b1; Irq = 1'b1; InstrPC = 32'h0040_0020;
        #1 check("irq_off_kill", RegWriteKill, 0);
        tick(); idle();
        check("irq_off_redirect", Redirect, 0);
        check("irq_off_exl", Exl, 0);
        check("irq_off_epc", EPC, 32'h0040_0010);
`endif

        // async reset during ENTER
        ExDone = 1'b1; Err = 1'b1; InstrPC = 32'h0040_0040;
        tick(); idle();
        check("ar_redirect_pre", Redirect, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_redirect", Redirect, 0);
        check("ar_target", Target, 0);
        check("ar_epc", EPC, 0);
        check("ar_cause", Cause, 0);
        check("ar_exl", Exl, 0);
        check("ar_busy", Busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_redirect", Redirect, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
